// File: rtl/fetch_unit_pkg.sv
// fetch_unit_pkg -- shared types and constants for the instruction fetch unit.
//   fetch_entry_t : one queued fetch (byte pc + instruction word)
//   NOP_INSTR     : canonical RV32 nop encoding (addi x0,x0,0)
//   PC_STEP       : byte increment between sequential fetches
//   FQ_DEPTH_DEF  : default fetch-queue depth
package fetch_unit_pkg;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
    localparam logic [31:0] PC_STEP      = 32'd4;
    localparam int          FQ_DEPTH_DEF = 2;

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue -- small circular FIFO of fetch entries.
// Ports:
//   clock, reset      : clock, async active-high reset (empties the queue)
//   push, wdata       : enqueue wdata at tail (caller guarantees not full unless popping)
//   pop               : dequeue head (caller guarantees not empty)
//   flush             : synchronous empty; overrides push/pop
//   count             : number of valid entries
//   head              : head entry, all-zero when empty
module fetch_queue
    import fetch_unit_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH_DEF,
    localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  fetch_entry_t  wdata,
    output logic [CW-1:0] count,
    output fetch_entry_t  head
);

    fetch_entry_t  slots [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    // Explicit wrap so non-power-of-two depths also work.
    function automatic logic [PW-1:0] bump(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) slots[i] <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                slots[wr_ptr] <= wdata;
                wr_ptr        <= bump(wr_ptr);
            end
            if (pop) rd_ptr <= bump(rd_ptr);
            count <= count + CW'(push) - CW'(pop);
        end
    end

    // Zeroed when empty so stale entries never leak to the outputs
    // (including while reset is held).
    assign head = (count != '0) ? slots[rd_ptr] : '0;

endmodule

// File: rtl/fetch_unit.sv
// fetch_unit -- sequential instruction fetch with a 2-entry fetch queue.
// The PC register addresses instruction memory combinationally; each cycle
// the returned word is pushed with its pc when the queue has room (or the
// head is leaving), otherwise the pc holds and the same word is re-read.
// A redirect flushes the queue and reloads the pc with the aligned target.
// Ports:
//   clock, reset             : clock, async active-high reset
//   imem_addr  [31:0] out    : word index = pc[31:2]
//   imem_instr [31:0] in     : instruction word for imem_addr
//   redirect, redirect_pc    : flush + jump request from execute
//   out_valid/out_ready      : decode handshake on the queue head
//   out_instr, out_pc        : head instruction and its byte pc
//   perf_fetched, perf_stall : present only with FETCH_PERF_CNT_EN defined
// Optional feature macro: FETCH_PERF_CNT_EN (performance counters).
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = FQ_DEPTH_DEF
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_stall,
`endif
    output logic [31:0] out_pc
);

    localparam int CW = $clog2(FQ_DEPTH + 1);

    logic [31:0]   pc;
    logic [CW-1:0] count;
    logic          full;
    logic          push;
    logic          pop;
    fetch_entry_t  wdata;
    fetch_entry_t  head;
    logic [31:0]   redirect_tgt;

    assign imem_addr    = {2'b00, pc[31:2]};
    assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

    assign full      = (count == CW'(FQ_DEPTH));
    assign out_valid = (count != '0);
    // Redirect kills the head even if decode is ready: nothing is delivered.
    assign pop  = out_valid && out_ready && !redirect;
    assign push = !redirect && (!full || pop);

    always_comb begin
        wdata       = '0;
        wdata.pc    = pc;
        wdata.instr = imem_instr;
    end

    fetch_queue #(.DEPTH(FQ_DEPTH)) u_queue (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .flush (redirect),
        .wdata (wdata),
        .count (count),
        .head  (head)
    );

    assign out_pc    = head.pc;
    assign out_instr = head.instr;

    // pc + PC_STEP wraps naturally modulo 2^32.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)         pc <= RESET_PC;
        else if (redirect) pc <= redirect_tgt;
        else if (push)     pc <= pc + PC_STEP;
    end

`ifdef FETCH_PERF_CNT_EN
    // A stall cycle is one where the queue is full, the head stays, and no
    // redirect is pending -- i.e. the fetch is blocked purely by back-pressure.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stall   <= '0;
        end else begin
            if (push) perf_fetched <= perf_fetched + 32'd1;
            if (full && !pop && !redirect) perf_stall <= perf_stall + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit -- self-checking bench for fetch_unit.
// A queue-based reference model tracks the expected fetch stream; memory
// contents are word_index ^ salt. A second instance with RESET_PC near the
// top of the address space checks pc wrap from reset.
// Optional feature macro: FETCH_PERF_CNT_EN (perf counter checks).
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam logic [31:0] RPC  = 32'h0000_0000;
    localparam logic [31:0] RPC2 = 32'hFFFF_FFF8;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] imem_addr, imem_instr = '0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        out_valid, out_ready = 1'b0;
    logic [31:0] out_instr, out_pc;

    logic [31:0] imem_addr2, imem_instr2 = '0;
    logic        out_valid2;
    logic [31:0] out_instr2, out_pc2;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_fetched, perf_stall, perf_fetched2, perf_stall2;
`endif

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(RPC), .FQ_DEPTH(2)) dut (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr), .imem_instr(imem_instr),
        .redirect(redirect), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instr(out_instr),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched), .perf_stall(perf_stall),
`endif
        .out_pc(out_pc)
    );

    fetch_unit #(.RESET_PC(RPC2), .FQ_DEPTH(2)) dut2 (
        .clock(clock), .reset(reset),
        .imem_addr(imem_addr2), .imem_instr(imem_instr2),
        .redirect(1'b0), .redirect_pc(32'h0),
        .out_valid(out_valid2), .out_ready(1'b1),
        .out_instr(out_instr2),
`ifdef FETCH_PERF_CNT_EN
        .perf_fetched(perf_fetched2), .perf_stall(perf_stall2),
`endif
        .out_pc(out_pc2)
    );

    logic [31:0] salt = '0;

    function automatic logic [31:0] memf(input logic [31:0] word_idx);
        return word_idx ^ salt;
    endfunction

    // Memory updates on negedge for the current address.
    always @(negedge clock) begin
        imem_instr  <= memf(imem_addr);
        imem_instr2 <= memf(imem_addr2);
    end

    // Reference model state
    fetch_entry_t q[$];
    logic [31:0]  m_pc;
    int           m_fetched, m_stall;
    logic         e_valid;
    logic [31:0]  e_pc, e_instr;

    int errors = 0;
    int checks = 0;

    task automatic model_reset();
        q.delete();
        m_pc = RPC; m_fetched = 0; m_stall = 0;
        e_valid = 1'b0; e_pc = '0; e_instr = '0;
    endtask

    // Drive one cycle's inputs, advance the model at the posedge, and
    // return #1 after the edge with e_* holding the expected head.
    task automatic cycle(input logic rdy, input logic rd, input logic [31:0] rpc);
        logic pop_m, push_m;
        fetch_entry_t ent;
        out_ready = rdy; redirect = rd; redirect_pc = rpc;
        @(posedge clock);
        if (rd) begin
            q.delete();
            m_pc = {rpc[31:2], 2'b00};
        end else begin
            pop_m  = (q.size() != 0) && rdy;
            push_m = (q.size() < 2) || pop_m;
            ent.pc = m_pc;
            ent.instr = memf({2'b00, m_pc[31:2]});
            if (pop_m) void'(q.pop_front());
            if (push_m) begin
                q.push_back(ent);
                m_pc = m_pc + 32'd4;
                m_fetched++;
            end else begin
                m_stall++;
            end
        end
        e_valid = (q.size() != 0);
        e_pc    = e_valid ? q[0].pc : 32'h0;
        e_instr = e_valid ? q[0].instr : 32'h0;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        out_ready = 1'b0; redirect = 1'b0;
        #1;
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL reset_outputs: got v=%0b pc=%h instr=%h, want v=0 pc=0 instr=0",
                     out_valid, out_pc, out_instr);
        end
        checks++;
        if (imem_addr !== 32'h0 || imem_addr2 !== 32'h3FFF_FFFE) begin
            errors++;
            $display("FAIL reset_pc: got addr=%h addr2=%h, want 0 and 3ffffffe",
                     imem_addr, imem_addr2);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_stream();
        salt = '0;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 1'b0, 32'h0);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {1'b1, 32'(i * 4), 32'(i)}) begin
                errors++;
                $display("FAIL stream[%0d]: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, 32'(i * 4), 32'(i));
            end
        end
    endtask

    task automatic test_backpressure();
        salt = '0;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1'b0, 1'b0, 32'h0);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {e_valid, e_pc, e_instr}) begin
                errors++;
                $display("FAIL hold[%0d]: got v=%0b pc=%h instr=%h, want v=%0b pc=%h instr=%h",
                         i, out_valid, out_pc, out_instr, e_valid, e_pc, e_instr);
            end
        end
        checks++;
        if (imem_addr !== 32'd2) begin
            errors++;
            $display("FAIL hold_addr: got imem_addr=%h, want 2", imem_addr);
        end
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'(k * 4)) begin
                errors++;
                $display("FAIL drain[%0d]: got v=%0b pc=%h, want v=1 pc=%h",
                         k, out_valid, out_pc, 32'(k * 4));
            end
            cycle(1'b1, 1'b0, 32'h0);
        end
    endtask

    task automatic test_redirect();
        salt = $urandom;
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b1, 1'b1, 32'h0000_0102);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL redirect_flush: got v=%0b, want v=0", out_valid);
        end
        cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, 32'h0000_0100, memf(32'd64)}) begin
            errors++;
            $display("FAIL redirect_target: got v=%0b pc=%h instr=%h, want v=1 pc=00000100 instr=%h",
                     out_valid, out_pc, out_instr, memf(32'd64));
        end
    endtask

    task automatic test_reset_pc_wrap();
        logic [31:0] exp_pc [3];
        exp_pc[0] = 32'hFFFF_FFF8; exp_pc[1] = 32'hFFFF_FFFC; exp_pc[2] = 32'h0000_0000;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, 1'b0, 32'h0);
            checks++;
            if (out_valid2 !== 1'b1 || out_pc2 !== exp_pc[k]) begin
                errors++;
                $display("FAIL wrap[%0d]: got v=%0b pc=%h, want v=1 pc=%h",
                         k, out_valid2, out_pc2, exp_pc[k]);
            end
        end
    endtask

    task automatic test_async_reset();
        salt = $urandom;
        do_reset();
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, out_pc, out_instr, imem_addr} !== {1'b0, 32'h0, 32'h0, 32'h0}) begin
            errors++;
            $display("FAIL async_reset: got v=%0b pc=%h instr=%h addr=%h, want all 0",
                     out_valid, out_pc, out_instr, imem_addr);
        end
        @(negedge clock);
        reset = 1'b0;
        model_reset();
        cycle(1'b1, 1'b0, 32'h0);
        checks++;
        if ({out_valid, out_pc, out_instr} !== {1'b1, RPC, memf(32'h0)}) begin
            errors++;
            $display("FAIL restart: got v=%0b pc=%h instr=%h, want v=1 pc=%h instr=%h",
                     out_valid, out_pc, out_instr, RPC, memf(32'h0));
        end
    endtask

    task automatic test_random();
        int bad = 0;
        salt = $urandom;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle(($urandom % 4) != 0, ($urandom % 16) == 0, $urandom);
            checks++;
            if ({out_valid, out_pc, out_instr} !== {e_valid, e_pc, e_instr} ||
                imem_addr !== {2'b00, m_pc[31:2]}) begin
                errors++;
                if (bad < 5)
                    $display("FAIL random[%0d]: got v=%0b pc=%h instr=%h addr=%h, want v=%0b pc=%h instr=%h addr=%h",
                             i, out_valid, out_pc, out_instr, imem_addr,
                             e_valid, e_pc, e_instr, {2'b00, m_pc[31:2]});
                bad++;
            end
        end
    endtask

`ifdef FETCH_PERF_CNT_EN
    task automatic test_perf();
        salt = $urandom;
        do_reset();
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 32'h0);
        for (int i = 0; i < 3; i++)  cycle(1'b0, 1'b0, 32'h0);
        checks++;
        if (perf_fetched !== 32'(m_fetched) || perf_stall !== 32'(m_stall)) begin
            errors++;
            $display("FAIL perf: got fetched=%0d stall=%0d, want fetched=%0d stall=%0d",
                     perf_fetched, perf_stall, m_fetched, m_stall);
        end
        for (int i = 0; i < 50; i++) cycle(($urandom % 3) == 0, ($urandom % 20) == 0, $urandom);
        checks++;
        if (perf_fetched !== 32'(m_fetched) || perf_stall !== 32'(m_stall)) begin
            errors++;
            $display("FAIL perf_random: got fetched=%0d stall=%0d, want fetched=%0d stall=%0d",
                     perf_fetched, perf_stall, m_fetched, m_stall);
        end
    endtask
`endif

    initial begin
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_reset_pc_wrap();
        test_async_reset();
        test_random();
`ifdef FETCH_PERF_CNT_EN
        test_perf();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
